// File: rtl/rx_engine.sv
// Asynchronous serial receiver with mid-bit sampling, parity/framing checks and a two-port read-back.
// Optional overrun detection is enabled by defining RX_OVF_DETECT_EN.
module rx_engine (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RX,
  input  logic       EIGHT,
  input  logic       PEN,
  input  logic       OHEL,
  input  logic [3:0] BAUD,
  input  logic [3:0] port_id,
  input  logic       read_strobe,
  output logic [7:0] UART_DATA,
  output logic       RX_STATUS
);

  typedef enum logic [1:0] {IDLE, START, DATA} state_t;

  state_t      state;
  logic        rx_meta;
  logic        rx_sync;
  logic [18:0] bit_time;
  logic [18:0] half_time;
  logic [18:0] cnt;
  logic [3:0]  bit_cnt;
  logic [3:0]  par_idx;
  logic [3:0]  last_idx;
  logic [9:0]  bits;
  logic        done;
  logic [7:0]  rx_byte;
  logic [7:0]  data_reg;
  logic        rxrdy;
  logic        perr;
  logic        ferr;
  logic        ovf;
  logic        new_perr;
  logic        new_ferr;
  logic        clr;

  always_comb begin
    bit_time = 19'd109;
    case (BAUD)
      4'h0: bit_time = 19'd333333;
      4'h1: bit_time = 19'd166667;
      4'h2: bit_time = 19'd83333;
      4'h3: bit_time = 19'd41667;
      4'h4: bit_time = 19'd20833;
      4'h5: bit_time = 19'd10417;
      4'h6: bit_time = 19'd5208;
      4'h7: bit_time = 19'd2604;
      4'h8: bit_time = 19'd1736;
      4'h9: bit_time = 19'd868;
      4'hA: bit_time = 19'd434;
      4'hB: bit_time = 19'd217;
      default: bit_time = 19'd109;
    endcase
  end

  assign half_time = bit_time >> 1;

  // bits[] holds samples after the start bit: data, optional parity, then stop
  assign par_idx  = EIGHT ? 4'd8 : 4'd7;
  assign last_idx = par_idx + {3'b000, PEN};
  assign rx_byte  = EIGHT ? bits[7:0] : {1'b0, bits[6:0]};
  assign new_perr = PEN & ((^rx_byte ^ OHEL) != bits[par_idx]);
  assign new_ferr = ~bits[last_idx];
  assign clr      = read_strobe && (port_id == 4'h0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= 19'd0;
      bit_cnt <= 4'd0;
      bits    <= 10'd0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= 19'd0;
          bit_cnt <= 4'd0;
          if (!rx_sync) state <= START;
        end
        START: begin
          if (cnt == half_time - 19'd1) begin
            cnt   <= 19'd0;
            state <= rx_sync ? IDLE : DATA;
          end else begin
            cnt <= cnt + 19'd1;
          end
        end
        DATA: begin
          if (cnt == bit_time - 19'd1) begin
            cnt           <= 19'd0;
            bits[bit_cnt] <= rx_sync;
            bit_cnt       <= bit_cnt + 4'd1;
            if (bit_cnt == last_idx) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 19'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A completing frame takes priority over a simultaneous clear
  always_ff @(posedge CLK) begin
    if (RESET) begin
      data_reg <= 8'h00;
      rxrdy    <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else if (done) begin
      data_reg <= rx_byte;
      rxrdy    <= 1'b1;
      perr     <= (perr & ~clr) | new_perr;
      ferr     <= (ferr & ~clr) | new_ferr;
    end else if (clr) begin
      rxrdy <= 1'b0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
    end
  end

`ifdef RX_OVF_DETECT_EN
  always_ff @(posedge CLK) begin
    if (RESET)     ovf <= 1'b0;
    else if (done) ovf <= (ovf & ~clr) | rxrdy;
    else if (clr)  ovf <= 1'b0;
  end
`else
  assign ovf = 1'b0;
`endif

  assign UART_DATA = port_id[0] ? {4'b0000, ovf, ferr, perr, rxrdy} : data_reg;
  assign RX_STATUS = rxrdy;

endmodule

// File: tb/tb_rx_engine.sv
// Directed bench for rx_engine: table of frames plus hand-written reset, clear and false-start sequences.
module tb_rx_engine;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       RX = 1'b1;
  logic       EIGHT = 1'b1;
  logic       PEN = 1'b0;
  logic       OHEL = 1'b0;
  logic [3:0] BAUD = 4'hC;
  logic [3:0] port_id = 4'h0;
  logic       read_strobe = 1'b0;
  logic [7:0] UART_DATA;
  logic       RX_STATUS;

  int tests = 0;
  int fails = 0;

`ifdef RX_OVF_DETECT_EN
  localparam logic [7:0] OVF_ST = 8'h09;
`else
  localparam logic [7:0] OVF_ST = 8'h01;
`endif

  rx_engine dut (
    .CLK(CLK), .RESET(RESET), .RX(RX), .EIGHT(EIGHT), .PEN(PEN), .OHEL(OHEL),
    .BAUD(BAUD), .port_id(port_id), .read_strobe(read_strobe),
    .UART_DATA(UART_DATA), .RX_STATUS(RX_STATUS)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] baud;
    logic       eight;
    logic       pen;
    logic       ohel;
    logic [7:0] dat;
    logic       par;
    logic       stp;
    logic       clr_first;
    logic [7:0] exp_dat;
    logic [7:0] exp_st;
  } vec_t;

  vec_t v[10];

  function automatic int kval(input logic [3:0] b);
    case (b)
      4'h0: return 333333;
      4'h1: return 166667;
      4'h2: return 83333;
      4'h3: return 41667;
      4'h4: return 20833;
      4'h5: return 10417;
      4'h6: return 5208;
      4'h7: return 2604;
      4'h8: return 1736;
      4'h9: return 868;
      4'hA: return 434;
      4'hB: return 217;
      default: return 109;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int k);
    RX = b;
    tick(k);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    int k;
    int nd;
    k  = kval(BAUD);
    nd = EIGHT ? 8 : 7;
    send_bit(1'b0, k);
    for (int i = 0; i < nd; i++) send_bit(d[i], k);
    if (PEN) send_bit(par, k);
    send_bit(stp, k);
    RX = 1'b1;
  endtask

  task automatic do_clear();
    read_strobe = 1'b1;
    port_id = 4'h0;
    tick(1);
    read_strobe = 1'b0;
  endtask

  task automatic read_both(input string tag, input logic [7:0] ed, input logic [7:0] es);
    port_id = 4'h0;
    #1 chk({tag, "_data"}, UART_DATA, ed);
    port_id = 4'h1;
    #1 chk({tag, "_status"}, UART_DATA, es);
    port_id = 4'h0;
  endtask

  initial begin
    //       baud  8     pen   ohel  data   par   stop  clr   exp    status
    v[0] = '{4'h9, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 8'h55, 8'h01};
    v[1] = '{4'hC, 1'b0, 1'b1, 1'b0, 8'h41, 1'b0, 1'b1, 1'b1, 8'h41, 8'h01};
    v[2] = '{4'hC, 1'b0, 1'b1, 1'b0, 8'h41, 1'b1, 1'b1, 1'b1, 8'h41, 8'h03};
    v[3] = '{4'hC, 1'b0, 1'b1, 1'b1, 8'h41, 1'b1, 1'b1, 1'b1, 8'h41, 8'h01};
    v[4] = '{4'hC, 1'b1, 1'b1, 1'b0, 8'hA7, 1'b1, 1'b1, 1'b1, 8'hA7, 8'h01};
    v[5] = '{4'hC, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 8'h05};
    v[6] = '{4'hC, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h7F, 8'h01};
    v[7] = '{4'hC, 1'b1, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1, 1'b0, 8'h12, OVF_ST};
    v[8] = '{4'hC, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 8'h03};
    v[9] = '{4'hB, 1'b1, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, 8'hC3, 8'h01};

    tick(3);
    RESET = 1'b0;
    chk("reset_rx_status", {7'd0, RX_STATUS}, 8'h00);
    read_both("reset", 8'h00, 8'h00);

    for (int i = 0; i < 10; i++) begin
      BAUD  = v[i].baud;
      EIGHT = v[i].eight;
      PEN   = v[i].pen;
      OHEL  = v[i].ohel;
      tick(2);
      if (v[i].clr_first) do_clear();
      tick(2);
      send_frame(v[i].dat, v[i].par, v[i].stp);
      tick(5);
      read_both($sformatf("vec%0d", i), v[i].exp_dat, v[i].exp_st);
      tick(v[i].stp ? 2 * kval(v[i].baud) : 12 * kval(v[i].baud));
    end

    // Read of port 1 must not clear; read of port 0 clears on the next edge
    read_strobe = 1'b1;
    port_id = 4'h1;
    tick(1);
    read_strobe = 1'b0;
    chk("no_clear_port1", {7'd0, RX_STATUS}, 8'h01);
    do_clear();
    chk("clear_rx_status", {7'd0, RX_STATUS}, 8'h00);
    read_both("after_clear", 8'hC3, 8'h00);

    // Short low glitch must be rejected as a false start
    BAUD = 4'h9;
    EIGHT = 1'b1;
    PEN = 1'b0;
    tick(2);
    RX = 1'b0;
    tick(300);
    RX = 1'b1;
    tick(10000);
    chk("false_start", {7'd0, RX_STATUS}, 8'h00);

    // Leave a frame pending, then reset in the middle of the next one
    BAUD = 4'hC;
    tick(2);
    send_frame(8'h96, 1'b0, 1'b1);
    tick(5);
    read_both("pre_reset", 8'h96, 8'h01);
    tick(200);
    send_bit(1'b0, 109);
    send_bit(1'b1, 109);
    send_bit(1'b0, 109);
    send_bit(1'b1, 109);
    send_bit(1'b0, 50);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    RX = 1'b1;
    chk("midreset_rx_status", {7'd0, RX_STATUS}, 8'h00);
    read_both("midreset", 8'h00, 8'h00);
    tick(2000);
    chk("post_reset_idle", {7'd0, RX_STATUS}, 8'h00);
    send_frame(8'h5A, 1'b0, 1'b1);
    tick(5);
    read_both("post_reset_frame", 8'h5A, 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
